// File: rtl/pakin_seq_chk.sv
// Packet sink for the far end of a pakout link: 4-phase req/ack receiver with
// address, data and redundancy sequence checking plus first-error capture.
module pakin_seq_chk #(
  parameter int unsigned ASZ      = 6,
  parameter int unsigned DSZ      = 4,
  parameter int unsigned RSZ      = 4,
  parameter int unsigned MIN_ADDR = 0,
  parameter int unsigned MAX_ADDR = 55,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             reset,
  output logic             ready,
  input  logic             i0_req,
  output logic             i0_ack,
  input  logic [ASZ-1:0]   i0_addr,
  input  logic [DSZ-1:0]   i0_dat,
  input  logic [RSZ-1:0]   i0_redun,
  output logic [DSZ-1:0]   o_ck_dat,
  output logic [CNT_W-1:0] o_pkt_cnt,
  output logic             o_err,
  output logic [DSZ-1:0]   fst_err_inp,
  output logic [DSZ-1:0]   fst_err_dat
);

  localparam int unsigned AD_W = (ASZ > DSZ) ? ASZ : DSZ;
  localparam int unsigned XW   = (AD_W > RSZ) ? AD_W : RSZ;

  typedef enum logic [1:0] {S_DRAIN, S_IDLE, S_CHECK, S_ACK} state_t;

  state_t           state_q, state_d;
  logic             req_m_q, req_s_q;
  logic [1:0]       fill_q, fill_d;
  logic             ack_q, ack_d;
  logic             ready_q, ready_d;
  logic [DSZ-1:0]   ck_dat_q, ck_dat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [DSZ-1:0]   fei_q, fei_d;
  logic [DSZ-1:0]   fed_q, fed_d;
  logic [ASZ-1:0]   exp_addr_q, exp_addr_d;
  logic [DSZ-1:0]   exp_dat_q, exp_dat_d;

  logic [XW-1:0]    xor_w;
  logic [RSZ-1:0]   red_exp;
  logic             addr_ok, dat_ok, red_ok;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q    <= S_DRAIN;
      req_m_q    <= 1'b0;
      req_s_q    <= 1'b0;
      fill_q     <= '0;
      ack_q      <= 1'b0;
      ready_q    <= 1'b0;
      ck_dat_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      fei_q      <= '0;
      fed_q      <= '0;
      exp_addr_q <= ASZ'(MIN_ADDR);
      exp_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_m_q    <= i0_req;
      req_s_q    <= req_m_q;
      fill_q     <= fill_d;
      ack_q      <= ack_d;
      ready_q    <= ready_d;
      ck_dat_q   <= ck_dat_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      fei_q      <= fei_d;
      fed_q      <= fed_d;
      exp_addr_q <= exp_addr_d;
      exp_dat_q  <= exp_dat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ck_dat_d   = ck_dat_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    fei_d      = fei_q;
    fed_d      = fed_q;
    exp_addr_d = exp_addr_q;
    exp_dat_d  = exp_dat_q;

    xor_w   = XW'(i0_addr) ^ XW'(i0_dat);
    red_exp = RSZ'(xor_w);
    addr_ok = (i0_addr == exp_addr_q);
    dat_ok  = (i0_dat == exp_dat_q);
    red_ok  = (i0_redun == red_exp);

    // The synchroniser is cleared by reset, so req_s only reflects the real
    // upstream level once it has refilled; DRAIN must not trust it before then.
    fill_d = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;

    case (state_q)
      S_DRAIN: if (fill_q == 2'd2 && !req_s_q) state_d = S_IDLE;
      S_IDLE:  if (req_s_q) state_d = S_CHECK;
      S_CHECK: begin
        state_d = S_ACK;
        if (addr_ok && dat_ok && red_ok) begin
          ck_dat_d = i0_dat;
        end else begin
          err_d = 1'b1;
          if (!err_q) begin
            fei_d = i0_dat;
            fed_d = exp_dat_q;
          end
        end
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        exp_dat_d  = exp_dat_q + DSZ'(1);
        exp_addr_d = (exp_addr_q == ASZ'(MAX_ADDR)) ? ASZ'(MIN_ADDR)
                                                    : exp_addr_q + ASZ'(1);
      end
      S_ACK:   if (!req_s_q) state_d = S_IDLE;
      default: state_d = S_DRAIN;
    endcase

    ack_d   = (state_d == S_ACK);
    ready_d = ready_q | (state_d == S_IDLE);
  end

  assign i0_ack      = ack_q;
  assign ready       = ready_q;
  assign o_ck_dat    = ck_dat_q;
  assign o_pkt_cnt   = cnt_q;
  assign o_err       = err_q;
  assign fst_err_inp = fei_q;
  assign fst_err_dat = fed_q;

endmodule

// File: tb/tb_pakin_seq_chk.sv
// Bench for pakin_seq_chk: upstream producer on its own clock (3:7 ratio),
// behavioural model of the expected sequence and first-error capture.
module tb_pakin_seq_chk;

  logic        i_clk = 1'b0;
  logic        uclk  = 1'b0;
  logic        reset = 1'b1;
  logic        ready;
  logic        i0_req = 1'b0;
  logic        i0_ack;
  logic [5:0]  i0_addr = '0;
  logic [3:0]  i0_dat = '0;
  logic [3:0]  i0_redun = '0;
  logic [3:0]  o_ck_dat;
  logic [15:0] o_pkt_cnt;
  logic        o_err;
  logic [3:0]  fst_err_inp;
  logic [3:0]  fst_err_dat;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int m_exp_addr, m_exp_dat, m_cnt, m_ck, m_fei, m_fed;
  bit m_err;

  pakin_seq_chk #(
    .ASZ(6), .DSZ(4), .RSZ(4), .MIN_ADDR(0), .MAX_ADDR(55), .CNT_W(16)
  ) dut (
    .i_clk(i_clk), .reset(reset), .ready(ready),
    .i0_req(i0_req), .i0_ack(i0_ack),
    .i0_addr(i0_addr), .i0_dat(i0_dat), .i0_redun(i0_redun),
    .o_ck_dat(o_ck_dat), .o_pkt_cnt(o_pkt_cnt), .o_err(o_err),
    .fst_err_inp(fst_err_inp), .fst_err_dat(fst_err_dat)
  );

  // i_clk rises at odd ns, uclk at even ns: upstream edges never race the DUT
  always #3 i_clk = ~i_clk;
  initial begin
    #1;
    forever #7 uclk = ~uclk;
  end

  task automatic model_reset();
    m_exp_addr = 0; m_exp_dat = 0; m_cnt = 0; m_ck = 0;
    m_fei = 0; m_fed = 0; m_err = 0;
  endtask

  task automatic model_pkt(input int a, input int d, input int r);
    bit ok;
    ok = (a == m_exp_addr) && (d == m_exp_dat) && (r == ((a ^ d) % 16));
    if (ok) m_ck = d;
    else begin
      if (!m_err) begin m_fei = d; m_fed = m_exp_dat; end
      m_err = 1;
    end
    if (m_cnt < 65535) m_cnt = m_cnt + 1;
    m_exp_dat  = (m_exp_dat + 1) % 16;
    m_exp_addr = (m_exp_addr == 55) ? 0 : m_exp_addr + 1;
  endtask

  task automatic send_pkt(input int a, input int d, input int r);
    int n;
    @(posedge uclk);
    i0_addr = 6'(a); i0_dat = 4'(d); i0_redun = 4'(r);
    i0_req = 1'b1;
    n = 0;
    while (!i0_ack && n < 40) begin @(posedge uclk); n++; end
    vectors++;
    if (i0_ack !== 1'b1) begin
      $display("FAIL handshake_rise: ack=%b required 1 within 40 cycles", i0_ack);
      miscompares++;
    end
    i0_req = 1'b0;
    n = 0;
    while (i0_ack && n < 40) begin @(posedge uclk); n++; end
    vectors++;
    if (i0_ack !== 1'b0) begin
      $display("FAIL handshake_fall: ack=%b required 0 within 40 cycles", i0_ack);
      miscompares++;
    end
    model_pkt(a, d, r);
  endtask

  task automatic send_good();
    send_pkt(m_exp_addr, m_exp_dat, (m_exp_addr ^ m_exp_dat) % 16);
  endtask

  task automatic do_reset();
    @(negedge i_clk) reset = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) reset = 1'b0;
    model_reset();
    repeat (4) @(posedge i_clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    vectors++;
    if ({i0_ack, ready, o_err} !== 3'b000 || o_ck_dat !== 4'd0 || o_pkt_cnt !== 16'd0 ||
        fst_err_inp !== 4'd0 || fst_err_dat !== 4'd0) begin
      $display("FAIL reset_state: ack=%b ready=%b err=%b ck=%0d cnt=%0d fei=%0d fed=%0d required all 0",
               i0_ack, ready, o_err, o_ck_dat, o_pkt_cnt, fst_err_inp, fst_err_dat);
      miscompares++;
    end
    @(negedge i_clk) reset = 1'b0;
    model_reset();
    repeat (6) @(posedge i_clk);
    #1;
    vectors++;
    if (ready !== 1'b1) begin
      $display("FAIL ready_after_reset: ready=%b required 1", ready); miscompares++;
    end
  endtask

  task automatic test_sequence();
    do_reset();
    for (int i = 0; i < 56; i++) send_good();
    vectors++;
    if (o_pkt_cnt !== 16'd56 || o_err !== 1'b0 || o_ck_dat !== 4'd7) begin
      $display("FAIL t1_full_seq: cnt=%0d err=%b ck=%0d required cnt=56 err=0 ck=7",
               o_pkt_cnt, o_err, o_ck_dat);
      miscompares++;
    end
    send_pkt(0, 8, 8);
    vectors++;
    if (o_pkt_cnt !== 16'd57 || o_err !== 1'b0 || o_ck_dat !== 4'd8) begin
      $display("FAIL t1_addr_wrap: cnt=%0d err=%b ck=%0d required cnt=57 err=0 ck=8",
               o_pkt_cnt, o_err, o_ck_dat);
      miscompares++;
    end
  endtask

  task automatic test_bad_data();
    do_reset();
    for (int i = 0; i < 5; i++) send_good();
    send_pkt(5, 9, (5 ^ 9) % 16);
    vectors++;
    if (o_err !== 1'b1 || fst_err_inp !== 4'd9 || fst_err_dat !== 4'd5 || o_ck_dat !== 4'd4) begin
      $display("FAIL t2_first_err: err=%b fei=%0d fed=%0d ck=%0d required 1/9/5/4",
               o_err, fst_err_inp, fst_err_dat, o_ck_dat);
      miscompares++;
    end
    send_pkt(6, 6, 0);
    vectors++;
    if (o_ck_dat !== 4'd6) begin
      $display("FAIL t2_recover: ck=%0d required 6", o_ck_dat); miscompares++;
    end
    send_good();
    send_pkt(8, 0, 8);
    vectors++;
    if (o_err !== 1'b1 || fst_err_inp !== 4'd9 || fst_err_dat !== 4'd5 ||
        o_ck_dat !== 4'd7 || o_pkt_cnt !== 16'd9) begin
      $display("FAIL t2_sticky: err=%b fei=%0d fed=%0d ck=%0d cnt=%0d required 1/9/5/7/9",
               o_err, fst_err_inp, fst_err_dat, o_ck_dat, o_pkt_cnt);
      miscompares++;
    end
  endtask

  task automatic test_bad_addr();
    do_reset();
    send_good(); send_good();
    send_pkt(60, 2, (60 ^ 2) % 16);
    vectors++;
    if (o_err !== 1'b1 || fst_err_inp !== 4'd2 || fst_err_dat !== 4'd2 || o_ck_dat !== 4'd1) begin
      $display("FAIL t3_addr_err: err=%b fei=%0d fed=%0d ck=%0d required 1/2/2/1",
               o_err, fst_err_inp, fst_err_dat, o_ck_dat);
      miscompares++;
    end
    send_pkt(3, 3, 0);
    vectors++;
    if (o_ck_dat !== 4'd3 || o_pkt_cnt !== 16'd4 || fst_err_inp !== 4'd2) begin
      $display("FAIL t3_no_cascade: ck=%0d cnt=%0d fei=%0d required 3/4/2",
               o_ck_dat, o_pkt_cnt, fst_err_inp);
      miscompares++;
    end
  endtask

  task automatic test_bad_redun();
    do_reset();
    send_pkt(0, 0, 15);
    vectors++;
    if (o_err !== 1'b1 || o_ck_dat !== 4'd0 || o_pkt_cnt !== 16'd1 ||
        fst_err_inp !== 4'd0 || fst_err_dat !== 4'd0) begin
      $display("FAIL t4_redun: err=%b ck=%0d cnt=%0d fei=%0d fed=%0d required 1/0/1/0/0",
               o_err, o_ck_dat, o_pkt_cnt, fst_err_inp, fst_err_dat);
      miscompares++;
    end
  endtask

  task automatic test_reset_in_ack();
    int n;
    do_reset();
    send_good();
    @(posedge uclk);
    i0_addr = 6'd1; i0_dat = 4'd1; i0_redun = 4'd0; i0_req = 1'b1;
    n = 0;
    while (!i0_ack && n < 40) begin @(posedge uclk); n++; end
    vectors++;
    if (i0_ack !== 1'b1) begin
      $display("FAIL t5_reach_ack: ack=%b required 1", i0_ack); miscompares++;
    end
    @(negedge i_clk) reset = 1'b1;
    @(posedge i_clk); #1;
    vectors++;
    if (i0_ack !== 1'b0 || o_pkt_cnt !== 16'd0 || o_err !== 1'b0 || ready !== 1'b0) begin
      $display("FAIL t5_reset_edge: ack=%b cnt=%0d err=%b ready=%b required 0/0/0/0",
               i0_ack, o_pkt_cnt, o_err, ready);
      miscompares++;
    end
    @(negedge i_clk) reset = 1'b0;
    model_reset();
    repeat (12) @(posedge i_clk); #1;
    vectors++;
    if (i0_ack !== 1'b0 || o_pkt_cnt !== 16'd0 || ready !== 1'b0) begin
      $display("FAIL t5_drain_hold: ack=%b cnt=%0d ready=%b required 0/0/0",
               i0_ack, o_pkt_cnt, ready);
      miscompares++;
    end
    @(negedge i_clk) i0_req = 1'b0;
    repeat (6) @(posedge i_clk); #1;
    vectors++;
    if (ready !== 1'b1 || o_pkt_cnt !== 16'd0) begin
      $display("FAIL t5_drain_exit: ready=%b cnt=%0d required 1/0", ready, o_pkt_cnt);
      miscompares++;
    end
    send_good(); send_good();
    vectors++;
    if (o_pkt_cnt !== 16'd2 || o_err !== 1'b0 || o_ck_dat !== 4'd1) begin
      $display("FAIL t5_resume: cnt=%0d err=%b ck=%0d required 2/0/1", o_pkt_cnt, o_err, o_ck_dat);
      miscompares++;
    end
  endtask

  task automatic test_timing();
    int n, rise_n, fall_n;
    do_reset();
    @(posedge uclk);
    i0_addr = 6'd0; i0_dat = 4'd0; i0_redun = 4'd0; i0_req = 1'b1;
    n = 0; rise_n = 0;
    while (rise_n == 0 && n < 20) begin
      @(posedge i_clk); n++; #1;
      if (i0_ack === 1'b1) rise_n = n;
    end
    vectors++;
    if (rise_n != 4) begin
      $display("FAIL t6_ack_rise: edges=%0d required 4", rise_n); miscompares++;
    end
    repeat (5) @(posedge i_clk); #1;
    vectors++;
    if (i0_ack !== 1'b1 || o_pkt_cnt !== 16'd1) begin
      $display("FAIL t6_ack_hold: ack=%b cnt=%0d required 1/1", i0_ack, o_pkt_cnt);
      miscompares++;
    end
    @(negedge i_clk) i0_req = 1'b0;
    n = 0; fall_n = 0;
    while (fall_n == 0 && n < 20) begin
      @(posedge i_clk); n++; #1;
      if (i0_ack === 1'b0) fall_n = n;
    end
    vectors++;
    if (fall_n != 3) begin
      $display("FAIL t6_ack_fall: edges=%0d required 3", fall_n); miscompares++;
    end
    model_pkt(0, 0, 0);
  endtask

  task automatic test_random();
    int a, d, r, kind;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge uclk);
      kind = $urandom_range(0, 19);
      a = m_exp_addr; d = m_exp_dat;
      if (kind == 0) d = (m_exp_dat + 1 + $urandom_range(0, 14)) % 16;
      if (kind == 1) a = $urandom_range(56, 63);
      r = (a ^ d) % 16;
      if (kind == 2) r = r ^ $urandom_range(1, 15);
      send_pkt(a, d, r);
      vectors++;
      if (o_pkt_cnt !== 16'(m_cnt) || o_ck_dat !== 4'(m_ck) || o_err !== m_err ||
          fst_err_inp !== 4'(m_fei) || fst_err_dat !== 4'(m_fed)) begin
        $display("FAIL rand_pkt%0d: cnt=%0d ck=%0d err=%b fei=%0d fed=%0d required %0d/%0d/%b/%0d/%0d",
                 i, o_pkt_cnt, o_ck_dat, o_err, fst_err_inp, fst_err_dat,
                 m_cnt, m_ck, m_err, m_fei, m_fed);
        miscompares++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequence();
    test_bad_data();
    test_bad_addr();
    test_bad_redun();
    test_reset_in_ack();
    test_timing();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
